// File: rtl/frame_capture_writer_pkg.sv
// rtl/frame_capture_writer_pkg.sv - shared constants, FSM encoding and pixel conversion for frame capture
package frame_capture_writer_pkg;

    localparam int FRAME_W      = 320;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int ADDR_W       = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_t;

    // Keep the top bits of each colour channel: R5[4:1], G6[5:2], B5[4:1].
    function automatic logic [11:0] rgb565_to_rgb444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/rgb565_assembler.sv
// rtl/rgb565_assembler.sv - pairs camera bytes into RGB565 pixels and converts them to RGB444
module rgb565_assembler
    import frame_capture_writer_pkg::*;
(
    input  logic        CLK25,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        href,
    input  logic [7:0]  din,
    output logic        pix_valid,
    output logic [11:0] pix_data
);

    logic       phase;
    logic [7:0] hi;

    always_ff @(posedge CLK25) begin
        if (rst_i) begin
            phase <= 1'b0;
            hi    <= 8'h00;
        end else if (!enable || !href) begin
            // A half-received pixel is dropped when the line or frame ends.
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
            if (!phase) begin
                hi <= din;
            end
        end
    end

    assign pix_valid = enable & href & phase;
    assign pix_data  = rgb565_to_rgb444(hi, din);

endmodule

// File: rtl/frame_capture_writer.sv
// rtl/frame_capture_writer.sv - camera frame capture into a 320x240 RGB444 frame buffer
module frame_capture_writer
    import frame_capture_writer_pkg::*;
#(
    parameter int FRAME_PIXELS = frame_capture_writer_pkg::FRAME_PIXELS,
    parameter int DECIMATE     = 1
) (
    input  logic              CLK25,
    input  logic              rst_i,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [11:0]       data,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] PTR_LIMIT = ADDR_W'(FRAME_PIXELS);

    cap_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              line_par;
    logic              pix_par;
    logic              href_d;
    logic              capture;
    logic              pix_valid;
    logic [11:0]       pix_data;
    logic              keep;

    // The cycle in which vsync rises aborts the line, so no pixel completes then.
    assign capture = (state == ST_ACTIVE) && !vsync;
    assign keep    = (DECIMATE == 0) || (!pix_par && !line_par);

    rgb565_assembler u_asm (
        .CLK25     (CLK25),
        .rst_i     (rst_i),
        .enable    (capture),
        .href      (href),
        .din       (din),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    always_ff @(posedge CLK25) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            we         <= 1'b0;
            address    <= '0;
            data       <= 12'h000;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            line_par   <= 1'b0;
            pix_par    <= 1'b0;
            href_d     <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            href_d     <= href;
            case (state)
                ST_IDLE: begin
                    if (vsync) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    wr_ptr   <= '0;
                    line_par <= 1'b0;
                    pix_par  <= 1'b0;
                    overflow <= 1'b0;
                    if (!vsync) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (vsync) begin
                        state      <= ST_SYNC;
                        frame_done <= 1'b1;
                    end else begin
                        if (!href) begin
                            pix_par <= 1'b0;
                        end else if (pix_valid) begin
                            pix_par <= ~pix_par;
                        end
                        if (href_d && !href) begin
                            line_par <= ~line_par;
                        end
                        if (pix_valid && keep) begin
                            if (wr_ptr == PTR_LIMIT) begin
                                overflow <= 1'b1;
                            end else begin
                                we      <= 1'b1;
                                address <= wr_ptr;
                                data    <= pix_data;
                                wr_ptr  <= wr_ptr + 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_writer.sv
// tb/tb_frame_capture_writer.sv - directed self-checking bench for frame_capture_writer
module tb_frame_capture_writer;

    logic        CLK25 = 1'b0;
    logic        rst_i;
    logic        vsync;
    logic        href;
    logic [7:0]  din;

    logic        we0, fd0, ov0;
    logic [16:0] a0;
    logic [11:0] d0;
    logic        we1, fd1, ov1;
    logic [16:0] a1;
    logic [11:0] d1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd0_cnt = 0;
    int fd1_cnt = 0;
    int last_byte_cyc = 0;

    logic [16:0] wa0[$];
    logic [11:0] wd0[$];
    int          wc0[$];
    logic [16:0] wa1[$];
    logic [11:0] wd1[$];

    logic [7:0]  line_buf[0:31];
    logic [11:0] exp_pix[0:3][0:7];

    frame_capture_writer #(.FRAME_PIXELS(16), .DECIMATE(0)) dut (
        .CLK25(CLK25), .rst_i(rst_i), .vsync(vsync), .href(href), .din(din),
        .we(we0), .address(a0), .data(d0), .frame_done(fd0), .overflow(ov0)
    );

    frame_capture_writer #(.FRAME_PIXELS(16), .DECIMATE(1)) dut_d (
        .CLK25(CLK25), .rst_i(rst_i), .vsync(vsync), .href(href), .din(din),
        .we(we1), .address(a1), .data(d1), .frame_done(fd1), .overflow(ov1)
    );

    always #20 CLK25 = ~CLK25;

    always @(posedge CLK25) cyc <= cyc + 1;

    always @(negedge CLK25) begin
        if (we0) begin
            wa0.push_back(a0);
            wd0.push_back(d0);
            wc0.push_back(cyc);
        end
        if (we1) begin
            wa1.push_back(a1);
            wd1.push_back(d1);
        end
        if (fd0) fd0_cnt++;
        if (fd1) fd1_cnt++;
    end

    function automatic logic [11:0] conv(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK25);
        #1;
    endtask

    task automatic clear_logs();
        wa0.delete(); wd0.delete(); wc0.delete();
        wa1.delete(); wd1.delete();
    endtask

    task automatic send_line(input int n);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            din = line_buf[i];
            last_byte_cyc = cyc;
            tick();
        end
        href = 1'b0;
        din  = 8'h00;
        tick();
        tick();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic load4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        line_buf[0] = b0; line_buf[1] = b1; line_buf[2] = b2; line_buf[3] = b3;
    endtask

    initial begin
        rst_i = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
        tick(); tick();
        rst_i = 1'b0;
        check("reset_we", we0, 0);
        check("reset_addr", a0, 0);
        check("reset_data", d0, 0);
        check("reset_fd", fd0, 0);
        check("reset_ovf", ov0, 0);
        check("reset_we_dec", we1, 0);

        // Capture starts mid-frame: nothing written until a full vsync period.
        load4(8'hF8, 8'h00, 8'h07, 8'hE0);
        send_line(4);
        check("idle_no_write", wa0.size(), 0);
        check("idle_no_write_dec", wa1.size(), 0);
        vsync_pulse();
        check("idle_no_frame_done", fd0_cnt, 0);

        // Two-pixel line, full and decimated
        clear_logs();
        load4(8'hF8, 8'h00, 8'h07, 8'hE0);
        send_line(4);
        check("basic_count", wa0.size(), 2);
        check("basic_addr0", wa0.size() > 0 ? wa0[0] : 17'h1ffff, 0);
        check("basic_data0", wd0.size() > 0 ? wd0[0] : 12'hfff, 12'hF00);
        check("basic_addr1", wa0.size() > 1 ? wa0[1] : 17'h1ffff, 1);
        check("basic_data1", wd0.size() > 1 ? wd0[1] : 12'hfff, 12'h0F0);
        check("basic_latency", wc0.size() > 1 ? wc0[1] : -1, last_byte_cyc + 1);
        check("dec_basic_count", wa1.size(), 1);
        check("dec_basic_data", wd1.size() > 0 ? wd1[0] : 12'hfff, 12'hF00);

        // Line cut after three bytes, then a clean line
        clear_logs();
        line_buf[0] = 8'h12; line_buf[1] = 8'h34; line_buf[2] = 8'h56;
        send_line(3);
        check("short_count", wa0.size(), 1);
        check("short_addr", wa0.size() > 0 ? wa0[0] : 17'h1ffff, 2);
        check("short_data", wd0.size() > 0 ? wd0[0] : 12'hfff, conv(8'h12, 8'h34));
        check("dec_odd_line", wa1.size(), 0);
        clear_logs();
        load4(8'hAB, 8'hCD, 8'h9A, 8'hBC);
        send_line(4);
        check("pair_count", wa0.size(), 2);
        check("pair_addr0", wa0.size() > 0 ? wa0[0] : 17'h1ffff, 3);
        check("pair_data0", wd0.size() > 0 ? wd0[0] : 12'hfff, conv(8'hAB, 8'hCD));
        check("pair_data1", wd0.size() > 1 ? wd0[1] : 12'hfff, conv(8'h9A, 8'hBC));
        check("dec_pair_count", wa1.size(), 1);
        check("dec_pair_addr", wa1.size() > 0 ? wa1[0] : 17'h1ffff, 1);
        check("dec_pair_data", wd1.size() > 0 ? wd1[0] : 12'hfff, conv(8'hAB, 8'hCD));
        check("no_ovf_small", ov0, 0);

        // End of frame: one-cycle frame_done right after vsync is sampled high
        fd0_cnt = 0; fd1_cnt = 0;
        vsync = 1'b1;
        tick();
        check("fd_pulse", fd0, 1);
        tick();
        check("fd_pulse_end", fd0, 0);
        repeat (2) tick();
        vsync = 1'b0;
        repeat (2) tick();
        check("fd_count", fd0_cnt, 1);
        check("fd_count_dec", fd1_cnt, 1);

        // Four lines of eight pixels: decimation keeps 8, full capture overflows at 16
        clear_logs();
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin
                line_buf[2*p]   = 8'(l * 37 + p * 11 + 3);
                line_buf[2*p+1] = 8'(~(l * 37 + p * 11 + 3) ^ p);
                exp_pix[l][p]   = conv(line_buf[2*p], line_buf[2*p+1]);
            end
            send_line(16);
        end
        check("dec_frame_count", wa1.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("dec_addr%0d", i), wa1.size() > i ? wa1[i] : 17'h1ffff, i);
            check($sformatf("dec_data%0d", i), wd1.size() > i ? wd1[i] : 12'hfff,
                  exp_pix[(i / 4) * 2][(i % 4) * 2]);
        end
        check("dec_no_ovf", ov1, 0);
        check("full_write_count", wa0.size(), 16);
        check("full_last_addr", wa0.size() > 15 ? wa0[15] : 17'h1ffff, 15);
        check("full_last_data", wd0.size() > 15 ? wd0[15] : 12'hfff, exp_pix[1][7]);
        check("full_ovf_set", ov0, 1);
        fd0_cnt = 0;
        vsync_pulse();
        check("ovf_cleared", ov0, 0);
        check("fd_count2", fd0_cnt, 1);

        // Reset mid-line
        clear_logs();
        href = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din = 8'(8'h40 + i);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_pre_addr", wa0.size() > 2 ? wa0[2] : 17'h1ffff, 2);
        check("midrst_we", we0, 0);
        check("midrst_addr", a0, 0);
        check("midrst_data", d0, 0);
        href = 1'b0;
        tick();
        clear_logs();
        load4(8'h11, 8'h22, 8'h33, 8'h44);
        send_line(4);
        check("midrst_idle", wa0.size(), 0);
        vsync_pulse();
        load4(8'hF8, 8'h00, 8'h07, 8'hE0);
        send_line(4);
        check("midrst_first_addr", wa0.size() > 0 ? wa0[0] : 17'h1ffff, 0);
        check("midrst_first_data", wd0.size() > 0 ? wd0[0] : 12'hfff, 12'hF00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
